// File: rtl/scan_pkg.sv
// Shared types and helpers for the SCAN channel-LLR buffer.
// LLR j of a packed word occupies bits [j*Q +: Q].
package scan_pkg;

   typedef enum logic [1:0] {
      BANK_EMPTY,
      BANK_FILLING,
      BANK_FULL,
      BANK_BUSY
   } bank_state_e;

   function automatic int beats(int n, int p);
      return n / p;
   endfunction

   function automatic int aw(int n, int p);
      return (n / p > 1) ? $clog2(n / p) : 1;
   endfunction

   function automatic int llr_lsb(int j, int q);
      return j * q;
   endfunction

endpackage

// File: rtl/scan_llr_bank.sv
// One codeword bank: 1W1R synchronous RAM with registered read.
// The array is deliberately left without reset.
module scan_llr_bank #(
   parameter int DEPTH = 16,
   parameter int W     = 384,
   parameter int AW    = 4
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem [DEPTH];
   logic [W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/scan_channel_buffer.sv
// Double-buffered channel-LLR store: one bank loads while the
// other is bound to the decoder core for all SCAN iterations.
module scan_channel_buffer
   import scan_pkg::*;
#(
   parameter  int N     = 1024,
   parameter  int P     = 64,
   parameter  int Q     = 6,
   localparam int BEATS = beats(N, P),
   localparam int AW    = aw(N, P),
   localparam int W     = P * Q
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   input  logic          dec_start,
   output logic          dec_ack,
   input  logic          dec_done,
   output logic          busy,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data,
   output logic          rd_valid,
   output logic [1:0]    full_cnt
);

   bank_state_e   state_q [2];
   bank_state_e   state_d [2];
   logic          wr_bank_q, wr_bank_d;
   logic [AW-1:0] wr_cnt_q, wr_cnt_d;
   logic          rd_sel_q, rd_sel_d;
   logic          act_bank_q, act_bank_d;
   logic          busy_q, busy_d;
   logic          ack_q, ack_d;
   logic          rd_valid_q, rd_valid_d;
   logic          rd_bank_q, rd_bank_d;

   logic          accept;
   logic          wr_last;
   logic          grant;
   logic          rel;
   logic [W-1:0]  rdata [2];

   assign accept  = in_valid && in_ready && !flush;
   assign wr_last = (wr_cnt_q == AW'(BEATS - 1));
   assign grant   = dec_start && (state_q[rd_sel_q] == BANK_FULL) &&
                    (!busy_q || dec_done);
   assign rel     = dec_done && busy_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q[0] <= BANK_EMPTY;
         state_q[1] <= BANK_EMPTY;
         wr_bank_q  <= 1'b0;
         wr_cnt_q   <= '0;
         rd_sel_q   <= 1'b0;
         act_bank_q <= 1'b0;
         busy_q     <= 1'b0;
         ack_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_bank_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_bank_q  <= wr_bank_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_sel_q   <= rd_sel_d;
         act_bank_q <= act_bank_d;
         busy_q     <= busy_d;
         ack_q      <= ack_d;
         rd_valid_q <= rd_valid_d;
         rd_bank_q  <= rd_bank_d;
      end
   end

   // Fill, release and grant always touch distinct banks.
   always_comb begin
      state_d    = state_q;
      wr_bank_d  = wr_bank_q;
      wr_cnt_d   = wr_cnt_q;
      rd_sel_d   = rd_sel_q;
      act_bank_d = act_bank_q;
      busy_d     = busy_q;
      ack_d      = grant;
      rd_valid_d = rd_en && busy_q;
      rd_bank_d  = act_bank_q;
      if (accept) begin
         if (wr_last) begin
            state_d[wr_bank_q] = BANK_FULL;
            wr_cnt_d           = '0;
            wr_bank_d          = ~wr_bank_q;
         end else begin
            state_d[wr_bank_q] = BANK_FILLING;
            wr_cnt_d           = wr_cnt_q + 1'b1;
         end
      end
      if (rel) begin
         state_d[act_bank_q] = BANK_EMPTY;
         busy_d              = 1'b0;
      end
      if (grant) begin
         state_d[rd_sel_q] = BANK_BUSY;
         act_bank_d        = rd_sel_q;
         rd_sel_d          = ~rd_sel_q;
         busy_d            = 1'b1;
      end
      if (flush) begin
         state_d[0] = BANK_EMPTY;
         state_d[1] = BANK_EMPTY;
         wr_bank_d  = 1'b0;
         wr_cnt_d   = '0;
         rd_sel_d   = 1'b0;
         busy_d     = 1'b0;
         ack_d      = 1'b0;
         rd_valid_d = 1'b0;
      end
   end

   always_comb begin
      in_ready = (state_q[wr_bank_q] == BANK_EMPTY) ||
                 (state_q[wr_bank_q] == BANK_FILLING);
      full_cnt = {1'b0, state_q[0] == BANK_FULL} +
                 {1'b0, state_q[1] == BANK_FULL};
      rd_data  = rd_valid_q ? rdata[rd_bank_q] : '0;
      dec_ack  = ack_q;
      busy     = busy_q;
      rd_valid = rd_valid_q;
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      scan_llr_bank #(
         .DEPTH (BEATS),
         .W     (W),
         .AW    (AW)
      ) u_bank (
         .clk_i   (clk),
         .we_i    (accept && (wr_bank_q == 1'(b))),
         .waddr_i (wr_cnt_q),
         .wdata_i (in_data),
         .re_i    (rd_en && busy_q && (act_bank_q == 1'(b))),
         .raddr_i (rd_addr),
         .rdata_o (rdata[b])
      );
   end

endmodule

// File: tb/tb_scan_channel_buffer.sv
// Directed bench for scan_channel_buffer at N=1024, P=64, Q=6.
module tb_scan_channel_buffer;
   import scan_pkg::*;

   localparam int N  = 1024;
   localparam int P  = 64;
   localparam int Q  = 6;
   localparam int W  = P * Q;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          dec_start = 1'b0;
   logic          dec_ack;
   logic          dec_done = 1'b0;
   logic          busy;
   logic          rd_en = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic [W-1:0]  rd_data;
   logic          rd_valid;
   logic [1:0]    full_cnt;

   int vectors = 0;
   int errors  = 0;

   scan_channel_buffer #(.N(N), .P(P), .Q(Q)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .dec_start (dec_start),
      .dec_ack   (dec_ack),
      .dec_done  (dec_done),
      .busy      (busy),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .full_cnt  (full_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] pat(input int v);
      logic [W-1:0] r;
      r = '0;
      for (int j = 0; j < P; j++) r[llr_lsb(j, Q) +: Q] = Q'(v);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] obs,
                      input logic [W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) tick();
      chk("rst_in_ready", W'(in_ready), W'(1));
      chk("rst_dec_ack", W'(dec_ack), W'(0));
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_rd_valid", W'(rd_valid), W'(0));
      chk("rst_rd_data", rd_data, '0);
      chk("rst_full_cnt", W'(full_cnt), W'(0));
      rst = 1'b0;
      tick();

      // codeword A into bank 0
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_data  = pat(i);
         tick();
      end
      in_valid = 1'b0;
      chk("A_full_cnt", W'(full_cnt), W'(1));
      chk("A_in_ready", W'(in_ready), W'(1));

      dec_start = 1'b1;
      tick();
      chk("A_ack", W'(dec_ack), W'(1));
      chk("A_busy", W'(busy), W'(1));
      chk("A_full_cnt_busy", W'(full_cnt), W'(0));
      dec_start = 1'b0;
      tick();
      chk("A_ack_pulse", W'(dec_ack), W'(0));

      // read A while loading B into bank 1
      for (int i = 0; i < 16; i++) begin
         rd_en    = 1'b1;
         rd_addr  = AW'(i);
         in_valid = 1'b1;
         in_data  = pat(16 + i);
         chk("B_in_ready", W'(in_ready), W'(1));
         tick();
         chk("A_rd_valid", W'(rd_valid), W'(1));
         chk("A_rd_data", rd_data, pat(i));
      end
      rd_en    = 1'b0;
      in_valid = 1'b0;
      chk("B_in_ready_drop", W'(in_ready), W'(0));
      chk("B_full_cnt", W'(full_cnt), W'(1));

      // done and start together: swap straight to B
      dec_done  = 1'b1;
      dec_start = 1'b1;
      tick();
      dec_done  = 1'b0;
      dec_start = 1'b0;
      chk("swap_ack", W'(dec_ack), W'(1));
      chk("swap_busy", W'(busy), W'(1));
      chk("swap_in_ready", W'(in_ready), W'(1));
      chk("swap_full_cnt", W'(full_cnt), W'(0));
      rd_en   = 1'b1;
      rd_addr = AW'(3);
      tick();
      rd_en = 1'b0;
      chk("swap_rd_data", rd_data, pat(19));
      chk("swap_busy_held", W'(busy), W'(1));

      dec_done = 1'b1;
      tick();
      dec_done = 1'b0;
      chk("B_release", W'(busy), W'(0));

      // request with no FULL bank, then fill C
      dec_start = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_data  = pat(32 + i);
         tick();
         chk("C_no_ack", W'(dec_ack), W'(0));
      end
      in_valid = 1'b0;
      tick();
      dec_start = 1'b0;
      chk("C_ack_late", W'(dec_ack), W'(1));

      // three iterations over C
      for (int pass = 0; pass < 3; pass++) begin
         for (int i = 0; i < 16; i++) begin
            rd_en   = 1'b1;
            rd_addr = AW'(15 - i);
            tick();
            chk("C_pass_data", rd_data, pat(32 + 15 - i));
         end
      end
      rd_en    = 1'b0;
      dec_done = 1'b1;
      tick();
      dec_done = 1'b0;
      rd_en    = 1'b1;
      rd_addr  = AW'(2);
      tick();
      rd_en = 1'b0;
      chk("idle_rd_valid", W'(rd_valid), W'(0));
      chk("idle_rd_data", rd_data, '0);

      // partial fill into bank 1, then flush
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         in_data  = pat(48 + i);
         tick();
      end
      in_valid = 1'b0;
      flush    = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_full_cnt", W'(full_cnt), W'(0));
      chk("flush_in_ready", W'(in_ready), W'(1));

      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_data  = pat(40 + i);
         tick();
      end
      in_valid = 1'b0;
      chk("D_full_cnt", W'(full_cnt), W'(1));
      dec_start = 1'b1;
      tick();
      dec_start = 1'b0;
      chk("D_ack", W'(dec_ack), W'(1));
      for (int i = 0; i < 16; i++) begin
         rd_en   = 1'b1;
         rd_addr = AW'(i);
         tick();
         chk("D_rd_data", rd_data, pat(40 + i));
      end

      // async reset in the middle of decode
      rst = 1'b1;
      #1;
      chk("rst_mid_busy", W'(busy), W'(0));
      chk("rst_mid_rd_valid", W'(rd_valid), W'(0));
      chk("rst_mid_full_cnt", W'(full_cnt), W'(0));
      tick();
      rst   = 1'b0;
      rd_en = 1'b0;
      tick();
      chk("post_rst_ack", W'(dec_ack), W'(0));
      chk("post_rst_rd_valid", W'(rd_valid), W'(0));
      chk("post_rst_in_ready", W'(in_ready), W'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/scan_channel_buffer.md
# scan_channel_buffer

Double-buffered channel-LLR store for the parametrised SCAN polar decoder. It accepts P quantised LLRs per beat from the demapper side and holds complete codewords across all SCAN iterations. It serves top-layer alpha reads to the decoder core. While the core decodes codeword k from one bank, codeword k+1 loads into the other bank, so back-to-back codewords run without load stalls.

## Interface
- N, 1024: code length (power of two, ≥ 2·P)
- P, 64: LLRs per beat / per read word
- Q, 6: bits per LLR
- derived: BEATS = N/P; AW = $clog2(BEATS)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous abort; behaves like reset on control state
- in_valid  in  1  load beat valid
- in_ready  out  1  load beat accepted when in_valid && in_ready
- in_data  in  P*Q  P LLRs; LLR j occupies bits [j*Q +: Q]
- dec_start  in  1  decoder requests the next codeword (level, sampled each cycle)
- dec_ack  out  1  one-cycle pulse: request granted, bank now bound to the decoder
- dec_done  in  1  one-cycle pulse: decoder releases its bank (all iterations finished)
- busy  out  1  a bank is bound to the decoder
- rd_en  in  1  read request
- rd_addr  in  AW  beat index within the bound codeword
- rd_data  out  P*Q  read word
- rd_valid  out  1  rd_data valid
- full_cnt  out  2  number of banks in FULL state

## Operation
- Two banks (0, 1), each BEATS × P*Q. Per-bank state: EMPTY, FILLING, FULL, BUSY.
- Write side registers:
  - wr_bank: initially 0.
  - wr_cnt: 0..BEATS-1.
- in_ready = state[wr_bank] ∈ {EMPTY, FILLING}. This is combinational, with no dependence on in_valid.
- Accepted beat:
  - Writes mem[wr_bank][wr_cnt] and increments wr_cnt.
  - Bank goes EMPTY→FILLING on the first beat.
  - On beat BEATS-1 the bank goes FULL, wr_cnt wraps to 0 and wr_bank toggles.
- Read-side registers:
  - rd_sel: next bank to hand out, initially 0.
  - act_bank: the bank currently bound to the decoder.
  - avail = state[rd_sel]==FULL.
- Grant condition: dec_start && avail && (!busy || dec_done). On grant:
  - state[rd_sel] becomes BUSY and act_bank takes rd_sel.
  - rd_sel toggles, busy is set and dec_ack pulses.
- An ungranted dec_start is ignored and produces no ack. The decoder holds dec_start until it sees dec_ack.
- Release on dec_done while busy: state[act_bank] becomes EMPTY and busy clears, unless a grant occurs in the same cycle (then busy stays 1).
  - Done and grant in the same cycle always target different banks.
- dec_done while !busy is ignored.
- Reads:
  - rd_en && busy: rd_data = mem[act_bank][rd_addr] and rd_valid=1 on the next cycle.
  - rd_en && !busy: rd_valid=0 and rd_data=0.
  - Any number of reads per codeword is allowed (multiple SCAN iterations).
- Write/read conflict is impossible: a BUSY bank never has in_ready asserted through it, because wr_bank points to it only when it is not writable.
- flush / rst:
  - All banks EMPTY; wr_bank=rd_sel=0, wr_cnt=0, busy=0.
  - A partial fill is discarded.
  - Memory contents are not cleared.
- full_cnt = count of banks in FULL state; it excludes BUSY.

## Timing
- Reset values: in_ready=1, dec_ack=0, busy=0, rd_valid=0, rd_data=0, full_cnt=0.
- Load throughput is 1 beat/cycle while a bank is writable. A codeword takes BEATS cycles minimum.
- Beat BEATS-1 accepted in cycle t: full_cnt increments in t+1, and a grant is possible in t+1.
- dec_ack is registered, asserted in the cycle after dec_start is sampled with grant true. busy rises in the same cycle as dec_ack.
- Read latency is 1 cycle, fully pipelined with one read per cycle.
- After dec_done at t, the bank is writable from t+1. in_ready rises at t+1 if wr_bank is that bank.
- flush has priority over every other input in the same cycle.
- rst asserted mid-fill or mid-decode clears control state immediately; no ack or valid is emitted afterwards until new activity.

## Structure
- Shared package scan_pkg holds:
  - the bank-state enum (EMPTY/FILLING/FULL/BUSY);
  - helper functions beats(N,P) and aw(N,P);
  - the LLR packing convention (bits [j*Q +: Q]).
- Sub-module scan_llr_bank: a simple 1W1R synchronous RAM of BEATS × P*Q with registered read and no reset on the array. It is instantiated twice.
- The top level holds the bank state registers, write/read pointers, grant logic and the output read mux.

## Test plan
- Reset, then load 16 beats (N=1024, P=64) with beat i = all LLRs equal i → full_cnt=1 after the last beat; dec_start → dec_ack one cycle later; reading rd_addr 0..15 returns beat i one cycle after each request.
- Load codeword B (values 16+i) during decode of A → in_ready stays 1 for 16 beats and then drops (bank 1 FULL, bank 0 BUSY); in_ready rises the cycle after dec_done.
- dec_done and dec_start in the same cycle with B FULL → dec_ack next cycle, busy never drops, rd_addr 3 returns 19.
- dec_start with no FULL bank → no dec_ack while held; complete the fill → dec_ack 2 cycles after the last beat.
- rd_en while !busy → rd_valid=0, rd_data=0; three full read passes of the same codeword (3 iterations) → identical data each pass.
- flush after 7 beats of a fill → full_cnt=0, wr_cnt=0; a fresh 16-beat load is then read back correctly. Repeat the case with async rst asserted mid-decode → busy=0 immediately.
